alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Synthesizable control sequencer that drives the CPU datapath's register/bus control strobes for one micro-operation sequence per request.
- Supports four sequence types: immediate register load via MDR, binary ALU op, unary ALU op (e.g. NOT, opcode 5'b10010), and wide ALU op writing LO/HI.
- Sits between the future control unit and the datapath; replaces per-operation hand-written control sequences.

Parameters:
- NUM_REGS, 16, number of general-purpose registers; width of rin/rout one-hot vectors.
- REG_IDX_W, 4, register index width; must be at least $clog2(NUM_REGS).
- OPC_W, 5, ALU opcode width.
- DATA_W, 32, immediate/data width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; sampled only in IDLE.
- op_class  in  2  00=LOAD, 01=BIN, 10=UNARY, 11=WIDE.
- opcode  in  OPC_W  ALU opcode, captured at accept.
- ra  in  REG_IDX_W  destination register index.
- rb  in  REG_IDX_W  source A index.
- rc  in  REG_IDX_W  source B index (BIN/WIDE only).
- imm  in  DATA_W  LOAD immediate.
- busy  out  1  high from the cycle after accept until DONE inclusive.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  one-cycle pulse on a rejected request.
- rin  out  NUM_REGS  one-hot register load enables.
- rout  out  NUM_REGS  one-hot register bus drives.
- mdr_read, mdr_in, mdr_out  out  1 each  MDR controls.
- mdata_out  out  DATA_W  memory data presented to MDR.
- yin, yout, zin, zlo_out, zhi_out, lo_in, hi_in  out  1 each  datapath strobes.
- alu_opcode  out  OPC_W  ALU operation select.

Behaviour:
- Reset (clr low, asynchronous): state IDLE. All outputs 0, including mdata_out and alu_opcode. Captured operands cleared.
- All outputs are registered and Moore-decoded from state plus captured operands. No combinational path from inputs to outputs.
- Accept: start=1 in IDLE with all used indices < NUM_REGS captures op_class, opcode, ra, rb, rc and imm, then moves to the first state of the sequence next cycle.
- start in any non-IDLE state is ignored; there is no queueing.
- Reject: a used index >= NUM_REGS pulses err for one cycle and the block stays IDLE.
- States and asserted outputs (everything else 0):
  - LD_A: mdr_read=1, mdr_in=1, mdata_out=imm.
  - LD_B: mdr_out=1, rin[ra]=1; mdata_out still held at imm.
  - OP_A: rout[rb]=1, yin=1.
  - OP_B: yout=1, zin=1, alu_opcode=opcode; additionally rout[rc]=1 for BIN/WIDE only.
  - OP_C: zlo_out=1; rin[ra]=1 for BIN/UNARY, lo_in=1 for WIDE.
  - OP_D (WIDE only): zhi_out=1, hi_in=1.
  - DONE: done=1, then IDLE.
- Transitions:
  - LOAD: LD_A, LD_B, DONE.
  - BIN/UNARY: OP_A, OP_B, OP_C, DONE.
  - WIDE: OP_A, OP_B, OP_C, OP_D, DONE.
- Latency, with accept at edge N:
  - LOAD: done at N+3.
  - BIN/UNARY: done at N+4.
  - WIDE: done at N+5.
- A new request can be accepted in the cycle after DONE.
- ra==rb or rb==rc is legal; the one-hot vectors carry that single bit.
- rin and rout are never both nonzero in the same cycle.
- Reset mid-sequence aborts immediately: all strobes drop at once, no done pulse.

Optional Feature:
- Macro SEQ_STEP_EN.
- Defined: adds input port step (1 bit). Every non-IDLE state holds, with its outputs stable, until step=1 is sampled on a rising edge; IDLE acceptance is unchanged.
- Undefined: no step port; each state lasts exactly one cycle.

Decomposition:
- Shared package alu_seq_pkg holds:
  - op_class encoding constants (OPC_LOAD, OPC_BIN, OPC_UNARY, OPC_WIDE);
  - the state enum;
  - ALU opcode constants, including ALU_NOT=5'b10010.
- One sub-module, reg_onehot_dec: index to NUM_REGS one-hot with an enable input; instantiated twice, for rin and rout.

Test Plan:
- LOAD, ra=0, imm=32'h0000000F:
  - LD_A cycle: mdr_read=mdr_in=1, mdata_out=0000000F.
  - LD_B cycle: mdr_out=1, rin=16'h0001.
  - done pulses 3 cycles after accept.
- UNARY, opcode=5'b10010, ra=0, rb=1:
  - OP_A: rout=16'h0002, yin=1.
  - OP_B: zin=1, alu_opcode=10010, rout=0.
  - OP_C: zlo_out=1, rin=16'h0001.
  - done at +4.
- WIDE, rb=2, rc=3:
  - OP_B: rout=16'h0008.
  - OP_C: zlo_out=1, lo_in=1.
  - OP_D: zhi_out=1, hi_in=1.
  - done at +5.
- BIN accepted, then start repeated on each of the next 3 cycles: only one done; second request accepted only after DONE.
- clr driven low during OP_B: all outputs 0 asynchronously; no done; after release a new LOAD completes normally.
- NUM_REGS=12, UNARY with rb=13: err pulse, busy stays 0, no strobes asserted.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared encodings for the ALU micro-operation sequencer.
// Holds the request class codes, ALU opcode constants, the FSM state type
// and the packed group of single-bit datapath strobes.
package alu_seq_pkg;

    localparam logic [1:0] OPC_LOAD  = 2'b00;
    localparam logic [1:0] OPC_BIN   = 2'b01;
    localparam logic [1:0] OPC_UNARY = 2'b10;
    localparam logic [1:0] OPC_WIDE  = 2'b11;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;
    localparam logic [4:0] ALU_MUL = 5'b01111;
    localparam logic [4:0] ALU_NOT = 5'b10010;

    typedef enum logic [2:0] {
        StIdle,
        StLdA,
        StLdB,
        StOpA,
        StOpB,
        StOpC,
        StOpD,
        StDone
    } seq_state_e;

    typedef struct packed {
        logic mdr_read;
        logic mdr_in;
        logic mdr_out;
        logic yin;
        logic yout;
        logic zin;
        logic zlo_out;
        logic zhi_out;
        logic lo_in;
        logic hi_in;
    } strobe_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request handshake plus datapath control bundle.
// master = requesting control unit, slave = the sequencer.
// With SEQ_STEP_EN defined the bundle also carries the step input.
interface alu_op_sequencer_if #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_IDX_W = 4,
    parameter int unsigned OPC_W     = 5,
    parameter int unsigned DATA_W    = 32
);
    logic                 start;
    logic [1:0]           op_class;
    logic [OPC_W-1:0]     opcode;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    logic [DATA_W-1:0]    imm;
`ifdef SEQ_STEP_EN
    logic                 step;
`endif
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [NUM_REGS-1:0]  rin;
    logic [NUM_REGS-1:0]  rout;
    logic                 mdr_read;
    logic                 mdr_in;
    logic                 mdr_out;
    logic [DATA_W-1:0]    mdata_out;
    logic                 yin;
    logic                 yout;
    logic                 zin;
    logic                 zlo_out;
    logic                 zhi_out;
    logic                 lo_in;
    logic                 hi_in;
    logic [OPC_W-1:0]     alu_opcode;

    modport master (
        output start, op_class, opcode, ra, rb, rc, imm,
`ifdef SEQ_STEP_EN
        output step,
`endif
        input  busy, done, err, rin, rout, mdr_read, mdr_in, mdr_out, mdata_out,
        input  yin, yout, zin, zlo_out, zhi_out, lo_in, hi_in, alu_opcode
    );

    modport slave (
        input  start, op_class, opcode, ra, rb, rc, imm,
`ifdef SEQ_STEP_EN
        input  step,
`endif
        output busy, done, err, rin, rout, mdr_read, mdr_in, mdr_out, mdata_out,
        output yin, yout, zin, zlo_out, zhi_out, lo_in, hi_in, alu_opcode
    );

endinterface

// File: rtl/alu_op_sequencer_reg_onehot_dec.sv
// reg_onehot_dec: register index to one-hot enable vector, all zero when en=0.
module reg_onehot_dec #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 4
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // One bit per register, set only for the selected index
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one datapath micro-operation sequence per accepted
// request (LOAD, BIN, UNARY, WIDE). Every output is a flop whose next value is
// decoded from the current state and the captured operands, so outputs follow
// the state register by one cycle and never depend on inputs combinationally.
// Optional macro SEQ_STEP_EN: non-idle states wait for bus.step=1 to advance.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_IDX_W = 4,
    parameter int unsigned OPC_W     = 5,
    parameter int unsigned DATA_W    = 32
) (
    input logic               clk,
    input logic               clr,
    alu_op_sequencer_if.slave bus
);

    seq_state_e           state_q, state_d;
    logic [1:0]           cls_q;
    logic [OPC_W-1:0]     opc_q, opc_d, alu_opcode_q;
    logic [REG_IDX_W-1:0] ra_q, rb_q, rc_q, rout_idx;
    logic [DATA_W-1:0]    imm_q, mdata_d, mdata_q;
    logic                 idx_ok, accept, reject, advance, rin_en, rout_en;
    logic                 busy_q, done_q, err_q;
    logic [NUM_REGS-1:0]  rin_d, rout_d, rin_q, rout_q;
    strobe_t              strb_d, strb_q;

    function automatic logic in_range(input logic [REG_IDX_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    // Range-check only the indices the requested sequence will drive
    always_comb begin
        case (bus.op_class)
            OPC_LOAD:  idx_ok = in_range(bus.ra);
            OPC_BIN:   idx_ok = in_range(bus.ra) && in_range(bus.rb) && in_range(bus.rc);
            OPC_UNARY: idx_ok = in_range(bus.ra) && in_range(bus.rb);
            default:   idx_ok = in_range(bus.rb) && in_range(bus.rc);
        endcase
    end

    assign accept = (state_q == StIdle) && bus.start && idx_ok;
    assign reject = (state_q == StIdle) && bus.start && !idx_ok;

`ifdef SEQ_STEP_EN
    assign advance = bus.step;
`else
    assign advance = 1'b1;
`endif

    // Next-state: fixed walk per class, optionally gated by step
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = (bus.op_class == OPC_LOAD) ? StLdA : StOpA;
            StLdA:   state_d = StLdB;
            StLdB:   state_d = StDone;
            StOpA:   state_d = StOpB;
            StOpB:   state_d = StOpC;
            StOpC:   state_d = (cls_q == OPC_WIDE) ? StOpD : StDone;
            StOpD:   state_d = StDone;
            default: state_d = StIdle;
        endcase
        if ((state_q != StIdle) && !advance) begin
            state_d = state_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture on accept; held for the whole sequence
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cls_q <= '0;
            opc_q <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            cls_q <= bus.op_class;
            opc_q <= bus.opcode;
            ra_q  <= bus.ra;
            rb_q  <= bus.rb;
            rc_q  <= bus.rc;
            imm_q <= bus.imm;
        end
    end

    // Strobe decode for the current state
    always_comb begin
        strb_d   = '0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rb_q;
        opc_d    = '0;
        mdata_d  = '0;
        case (state_q)
            StLdA: begin
                strb_d.mdr_read = 1'b1;
                strb_d.mdr_in   = 1'b1;
                mdata_d         = imm_q;
            end
            StLdB: begin
                strb_d.mdr_out = 1'b1;
                rin_en         = 1'b1;
                mdata_d        = imm_q;
            end
            StOpA: begin
                rout_en    = 1'b1;
                strb_d.yin = 1'b1;
            end
            StOpB: begin
                strb_d.yout = 1'b1;
                strb_d.zin  = 1'b1;
                opc_d       = opc_q;
                rout_idx    = rc_q;
                rout_en     = (cls_q == OPC_BIN) || (cls_q == OPC_WIDE);
            end
            StOpC: begin
                strb_d.zlo_out = 1'b1;
                if (cls_q == OPC_WIDE) begin
                    strb_d.lo_in = 1'b1;
                end else begin
                    rin_en = 1'b1;
                end
            end
            StOpD: begin
                strb_d.zhi_out = 1'b1;
                strb_d.hi_in   = 1'b1;
            end
            default: ;
        endcase
    end

    reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_rin_dec (
        .idx   (ra_q),
        .en    (rin_en),
        .onehot(rin_d)
    );

    reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_rout_dec (
        .idx   (rout_idx),
        .en    (rout_en),
        .onehot(rout_d)
    );

    // Output registers; busy covers the cycle after accept through the done cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rin_q        <= '0;
            rout_q       <= '0;
            strb_q       <= '0;
            mdata_q      <= '0;
            alu_opcode_q <= '0;
        end else begin
            busy_q       <= (state_d != StIdle) || (state_q == StDone);
            done_q       <= (state_q == StDone);
            err_q        <= reject;
            rin_q        <= rin_d;
            rout_q       <= rout_d;
            strb_q       <= strb_d;
            mdata_q      <= mdata_d;
            alu_opcode_q <= opc_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rin        = rin_q;
    assign bus.rout       = rout_q;
    assign bus.mdr_read   = strb_q.mdr_read;
    assign bus.mdr_in     = strb_q.mdr_in;
    assign bus.mdr_out    = strb_q.mdr_out;
    assign bus.mdata_out  = mdata_q;
    assign bus.yin        = strb_q.yin;
    assign bus.yout       = strb_q.yout;
    assign bus.zin        = strb_q.zin;
    assign bus.zlo_out    = strb_q.zlo_out;
    assign bus.zhi_out    = strb_q.zhi_out;
    assign bus.lo_in      = strb_q.lo_in;
    assign bus.hi_in      = strb_q.hi_in;
    assign bus.alu_opcode = alu_opcode_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives requests cycle by cycle from a stimulus schedule
// and compares every sampled output cycle against a schedule of expected
// output snapshots built from the sequence tables.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int MAXC = 256;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] rin;
        logic [15:0] rout;
        logic        mdr_read;
        logic        mdr_in;
        logic        mdr_out;
        logic [31:0] mdata;
        logic        yin;
        logic        yout;
        logic        zin;
        logic        zlo;
        logic        zhi;
        logic        lo;
        logic        hi;
        logic [4:0]  opc;
    } snap_t;

    typedef struct packed {
        logic        start;
        logic [1:0]  cls;
        logic [4:0]  opc;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [31:0] imm;
    } req_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.NUM_REGS(16), .REG_IDX_W(4), .OPC_W(5), .DATA_W(32)) bus ();
    alu_op_sequencer_if #(.NUM_REGS(12), .REG_IDX_W(4), .OPC_W(5), .DATA_W(32)) bus12 ();

    alu_op_sequencer #(.NUM_REGS(16), .REG_IDX_W(4), .OPC_W(5), .DATA_W(32)) dut (
        .clk(clk), .clr(clr), .bus(bus)
    );
    alu_op_sequencer #(.NUM_REGS(12), .REG_IDX_W(4), .OPC_W(5), .DATA_W(32)) dut12 (
        .clk(clk), .clr(clr), .bus(bus12)
    );

`ifdef SEQ_STEP_EN
    initial begin
        bus.step   = 1'b1;
        bus12.step = 1'b1;
    end
`endif

    req_t  stim  [MAXC];
    snap_t exp_s [MAXC];
    snap_t obs   [MAXC];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic snap_t sample(input bit use12);
        snap_t s;
        if (use12) begin
            s = {bus12.busy, bus12.done, bus12.err, 4'b0, bus12.rin, 4'b0, bus12.rout,
                 bus12.mdr_read, bus12.mdr_in, bus12.mdr_out, bus12.mdata_out, bus12.yin,
                 bus12.yout, bus12.zin, bus12.zlo_out, bus12.zhi_out, bus12.lo_in,
                 bus12.hi_in, bus12.alu_opcode};
        end else begin
            s = {bus.busy, bus.done, bus.err, bus.rin, bus.rout, bus.mdr_read, bus.mdr_in,
                 bus.mdr_out, bus.mdata_out, bus.yin, bus.yout, bus.zin, bus.zlo_out,
                 bus.zhi_out, bus.lo_in, bus.hi_in, bus.alu_opcode};
        end
        return s;
    endfunction

    task automatic drive(input req_t r, input bit use12);
        if (use12) begin
            bus12.start = r.start; bus12.op_class = r.cls; bus12.opcode = r.opc;
            bus12.ra = r.ra; bus12.rb = r.rb; bus12.rc = r.rc; bus12.imm = r.imm;
        end else begin
            bus.start = r.start; bus.op_class = r.cls; bus.opcode = r.opc;
            bus.ra = r.ra; bus.rb = r.rb; bus.rc = r.rc; bus.imm = r.imm;
        end
    endtask

    function automatic req_t rand_req(input bit st);
        req_t r;
        r.start = st;
        r.cls   = 2'($urandom);
        r.opc   = 5'($urandom);
        r.ra    = 4'($urandom);
        r.rb    = 4'($urandom);
        r.rc    = 4'($urandom);
        r.imm   = $urandom;
        return r;
    endfunction

    function automatic int seq_len(input logic [1:0] cls);
        if (cls == OPC_LOAD) return 4;
        if (cls == OPC_WIDE) return 6;
        return 5;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < MAXC; i++) begin
            stim[i]  = '0;
            exp_s[i] = '0;
            obs[i]   = '0;
        end
    endtask

    // Expected outputs of one request accepted at the edge ending stimulus slot k0;
    // slot k0 itself only shows busy, the listed strobes follow one per cycle.
    task automatic model_add(input req_t r, input int k0);
        snap_t       s;
        logic [15:0] a_hot, b_hot, c_hot;
        int          k;
        a_hot = 16'd1 << r.ra;
        b_hot = 16'd1 << r.rb;
        c_hot = 16'd1 << r.rc;
        s = '0; s.busy = 1'b1; exp_s[k0] = s;
        k = k0 + 1;
        if (r.cls == OPC_LOAD) begin
            s = '0; s.busy = 1'b1; s.mdr_read = 1'b1; s.mdr_in = 1'b1; s.mdata = r.imm;
            exp_s[k] = s; k++;
            s = '0; s.busy = 1'b1; s.mdr_out = 1'b1; s.rin = a_hot; s.mdata = r.imm;
            exp_s[k] = s; k++;
        end else begin
            s = '0; s.busy = 1'b1; s.rout = b_hot; s.yin = 1'b1;
            exp_s[k] = s; k++;
            s = '0; s.busy = 1'b1; s.yout = 1'b1; s.zin = 1'b1; s.opc = r.opc;
            if (r.cls != OPC_UNARY) s.rout = c_hot;
            exp_s[k] = s; k++;
            s = '0; s.busy = 1'b1; s.zlo = 1'b1;
            if (r.cls == OPC_WIDE) s.lo = 1'b1;
            else s.rin = a_hot;
            exp_s[k] = s; k++;
            if (r.cls == OPC_WIDE) begin
                s = '0; s.busy = 1'b1; s.zhi = 1'b1; s.hi = 1'b1;
                exp_s[k] = s; k++;
            end
        end
        s = '0; s.busy = 1'b1; s.done = 1'b1; exp_s[k] = s;
    endtask

    // stim[c] is presented before edge c; obs[c] is sampled after edge c
    task automatic run(input int ncyc, input bit use12);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c > 0) obs[c-1] = sample(use12);
            drive(stim[c], use12);
        end
        @(negedge clk);
        obs[ncyc-1] = sample(use12);
        drive(req_t'('0), use12);
    endtask

    task automatic test_reset();
        snap_t s;
        s = sample(0);
        n_checks++;
        if (s !== '0) begin
            n_fail++; $display("FAIL reset16 got %h want 0", s);
        end
        s = sample(1);
        n_checks++;
        if (s !== '0) begin
            n_fail++; $display("FAIL reset12 got %h want 0", s);
        end
    endtask

    task automatic test_load();
        req_t r;
        clear_sched();
        r = rand_req(1); r.cls = OPC_LOAD; r.ra = 4'd0; r.imm = 32'h0000000F;
        stim[0] = r; model_add(r, 0);
        run(6, 0);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (obs[k] !== exp_s[k]) begin
                n_fail++; $display("FAIL load k=%0d got %h want %h", k, obs[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_unary();
        req_t r;
        clear_sched();
        r = rand_req(1); r.cls = OPC_UNARY; r.opc = ALU_NOT; r.ra = 4'd0; r.rb = 4'd1;
        stim[0] = r; model_add(r, 0);
        run(7, 0);
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (obs[k] !== exp_s[k]) begin
                n_fail++; $display("FAIL unary k=%0d got %h want %h", k, obs[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_wide();
        req_t r;
        clear_sched();
        r = rand_req(1); r.cls = OPC_WIDE; r.rb = 4'd2; r.rc = 4'd3;
        stim[0] = r; model_add(r, 0);
        run(8, 0);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (obs[k] !== exp_s[k]) begin
                n_fail++; $display("FAIL wide k=%0d got %h want %h", k, obs[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        req_t r;
        int   nd;
        clear_sched();
        r = rand_req(1); r.cls = OPC_BIN;
        stim[0] = r; model_add(r, 0);
        for (int j = 1; j <= 3; j++) stim[j] = rand_req(1);
        run(8, 0);
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            nd += int'(obs[k].done);
            n_checks++;
            if (obs[k] !== exp_s[k]) begin
                n_fail++; $display("FAIL ignore_start k=%0d got %h want %h", k, obs[k], exp_s[k]);
            end
        end
        n_checks++;
        if (nd !== 1) begin
            n_fail++; $display("FAIL done_count got %0d want 1", nd);
        end
        // second request presented in the done cycle is taken immediately
        clear_sched();
        r = rand_req(1); r.cls = OPC_LOAD;
        stim[0] = r; model_add(r, 0);
        r = rand_req(1); r.cls = OPC_WIDE;
        stim[4] = r; model_add(r, 4);
        run(12, 0);
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (obs[k] !== exp_s[k]) begin
                n_fail++; $display("FAIL b2b k=%0d got %h want %h", k, obs[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_random();
        req_t r;
        int   k, len;
        clear_sched();
        k = 0;
        for (int n = 0; n < 25; n++) begin
            r = rand_req(1);
            stim[k] = r; model_add(r, k);
            len = seq_len(r.cls);
            for (int j = 1; j < len; j++) stim[k+j] = rand_req(1'($urandom));
            k += len + int'($urandom_range(0, 2));
        end
        run(k + 2, 0);
        for (int i = 0; i < k + 2; i++) begin
            n_checks++;
            if (obs[i] !== exp_s[i]) begin
                n_fail++; $display("FAIL random k=%0d got %h want %h", i, obs[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_t  r;
        snap_t s;
        clear_sched();
        r = rand_req(1); r.cls = OPC_BIN;
        model_add(r, 0);
        @(negedge clk);
        drive(r, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) drive(req_t'('0), 0);
            obs[c] = sample(0);
        end
        n_checks++;
        if (obs[2] !== exp_s[2]) begin
            n_fail++; $display("FAIL mid_opb got %h want %h", obs[2], exp_s[2]);
        end
        #2 clr = 1'b0;
        #1 s = sample(0);
        n_checks++;
        if (s !== '0) begin
            n_fail++; $display("FAIL async_clear got %h want 0", s);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s = sample(0);
            n_checks++;
            if (s !== '0) begin
                n_fail++; $display("FAIL abort_quiet c=%0d got %h want 0", c, s);
            end
        end
        clr = 1'b1;
        clear_sched();
        r = rand_req(1); r.cls = OPC_LOAD;
        stim[0] = r; model_add(r, 0);
        run(6, 0);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (obs[k] !== exp_s[k]) begin
                n_fail++; $display("FAIL post_abort k=%0d got %h want %h", k, obs[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_reject();
        req_t r;
        // UNARY with rb=13 and BIN with rc=12 both exceed NUM_REGS=12
        for (int t = 0; t < 2; t++) begin
            clear_sched();
            r = rand_req(1); r.ra = 4'd2; r.rb = 4'd5;
            if (t == 0) begin
                r.cls = OPC_UNARY; r.rb = 4'd13;
            end else begin
                r.cls = OPC_BIN; r.rc = 4'd12;
            end
            stim[0] = r;
            exp_s[0].err = 1'b1;
            run(6, 1);
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (obs[k] !== exp_s[k]) begin
                    n_fail++;
                    $display("FAIL reject%0d k=%0d got %h want %h", t, k, obs[k], exp_s[k]);
                end
            end
        end
        clear_sched();
        r = rand_req(1); r.cls = OPC_LOAD; r.ra = 4'd11;
        stim[0] = r; model_add(r, 0);
        run(6, 1);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (obs[k] !== exp_s[k]) begin
                n_fail++; $display("FAIL top_index k=%0d got %h want %h", k, obs[k], exp_s[k]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(req_t'('0), 0);
        drive(req_t'('0), 1);
        #1 clr = 1'b0;
        #2;
        test_reset();
        repeat (2) @(negedge clk);
        clr = 1'b1;
        test_load();
        test_unary();
        test_wide();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_reject();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
